// File: rtl/bomba_alternador.sv
// Duplex pump lead/lag scheduler for tank filling.
// Alternates the lead pump per completed fill cycle, adds the lag pump on
// persistent demand, enforces minimum run/rest times and traps invalid
// sensor codes in a fault state.
// Optional feature macro: BOMBA_CICLOS_EN builds the completed-cycle counter
// behind ciclos_o; when undefined ciclos_o is tied to zero.
module bomba_alternador #(
  parameter int unsigned MIN_ON     = 16,
  parameter int unsigned MIN_OFF    = 8,
  parameter int unsigned ASSIST_CYC = 32,
  parameter int unsigned TW         = 8
) (
  input  logic       ck,
  input  logic       rst_i,
  input  logic [2:0] sensores_i,
  output logic       bomba_a_o,
  output logic       bomba_b_o,
  output logic       alarma_o,
  output logic       lider_o,
  output logic [2:0] estado_o,
  output logic [7:0] ciclos_o
);

  localparam logic [TW-1:0] ON_LIM     = TW'(MIN_ON - 1);
  localparam logic [TW-1:0] OFF_LIM    = TW'(MIN_OFF - 1);
  localparam logic [TW-1:0] ASSIST_LIM = TW'(ASSIST_CYC - 1);

  typedef enum logic [2:0] {
    REPOSO       = 3'd0,
    MARCHA_LIDER = 3'd1,
    MARCHA_AMBAS = 3'd2,
    DESCANSO     = 3'd3,
    FALLA        = 3'd4
  } estado_t;

  logic [2:0]    s1;
  logic [2:0]    s;
  estado_t       estado;
  estado_t       estado_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic          lider;
  logic          lider_nxt;
  logic          valido;

  // Two-flop synchronizer for the level sensors
  always_ff @(posedge ck or posedge rst_i) begin
    if (rst_i) begin
      s1 <= 3'b000;
      s  <= 3'b000;
    end else begin
      s1 <= sensores_i;
      s  <= s1;
    end
  end

  assign valido = (s == 3'b000) || (s == 3'b001) || (s == 3'b011) || (s == 3'b111);

  // Next-state, lead toggle and timer update
  always_comb begin
    estado_nxt = estado;
    lider_nxt  = lider;
    if (!valido && estado != FALLA) begin
      estado_nxt = FALLA;
    end else begin
      unique case (estado)
        REPOSO: begin
          if (s == 3'b000) estado_nxt = MARCHA_LIDER;
        end
        MARCHA_LIDER: begin
          // Stop has priority over assist; an early full reading is ignored
          if (s == 3'b111 && timer >= ON_LIM) begin
            estado_nxt = DESCANSO;
            lider_nxt  = ~lider;
          end else if (s == 3'b000 && timer == ASSIST_LIM) begin
            estado_nxt = MARCHA_AMBAS;
          end
        end
        MARCHA_AMBAS: begin
          if (s == 3'b111) begin
            estado_nxt = DESCANSO;
            lider_nxt  = ~lider;
          end
        end
        DESCANSO: begin
          if (timer == OFF_LIM) estado_nxt = REPOSO;
        end
        FALLA: begin
          if (valido && timer == OFF_LIM) estado_nxt = DESCANSO;
        end
        default: estado_nxt = REPOSO;
      endcase
    end

    if (estado_nxt != estado) begin
      timer_nxt = '0;
    end else if (estado == FALLA && !valido) begin
      timer_nxt = '0;
    end else if (timer != '1) begin
      timer_nxt = timer + TW'(1);
    end else begin
      timer_nxt = timer;
    end
  end

  // State, timer, lead and registered pump/alarm outputs
  always_ff @(posedge ck or posedge rst_i) begin
    if (rst_i) begin
      estado    <= REPOSO;
      timer     <= '0;
      lider     <= 1'b0;
      bomba_a_o <= 1'b0;
      bomba_b_o <= 1'b0;
      alarma_o  <= 1'b0;
    end else begin
      estado    <= estado_nxt;
      timer     <= timer_nxt;
      lider     <= lider_nxt;
      bomba_a_o <= (estado_nxt == MARCHA_AMBAS) || (estado_nxt == MARCHA_LIDER && !lider_nxt);
      bomba_b_o <= (estado_nxt == MARCHA_AMBAS) || (estado_nxt == MARCHA_LIDER && lider_nxt);
      alarma_o  <= (estado_nxt == FALLA);
    end
  end

  assign estado_o = estado;
  assign lider_o  = lider;

`ifdef BOMBA_CICLOS_EN
  logic [7:0] ciclos;
  logic       fin_ciclo;

  assign fin_ciclo = (estado == MARCHA_LIDER || estado == MARCHA_AMBAS) && (estado_nxt == DESCANSO);

  // Saturating count of completed fill cycles
  always_ff @(posedge ck or posedge rst_i) begin
    if (rst_i) begin
      ciclos <= 8'd0;
    end else if (fin_ciclo && ciclos != 8'hFF) begin
      ciclos <= ciclos + 8'd1;
    end
  end

  assign ciclos_o = ciclos;
`else
  assign ciclos_o = 8'd0;
`endif

endmodule

// File: tb/tb_bomba_alternador.sv
// Self-checking bench for bomba_alternador: directed vector table,
// async reset, fault recovery, randomized run against a reference model,
// and the completed-cycle counter (BOMBA_CICLOS_EN aware).
module tb_bomba_alternador;

  localparam int MIN_ON     = 16;
  localparam int MIN_OFF    = 8;
  localparam int ASSIST_CYC = 32;

`ifdef BOMBA_CICLOS_EN
  localparam bit CICLOS_EN = 1'b1;
`else
  localparam bit CICLOS_EN = 1'b0;
`endif

  logic       ck;
  logic       rst_i;
  logic [2:0] sensores_i;
  logic       bomba_a_o;
  logic       bomba_b_o;
  logic       alarma_o;
  logic       lider_o;
  logic [2:0] estado_o;
  logic [7:0] ciclos_o;

  int tests;
  int fails;

  bomba_alternador dut (
    .ck        (ck),
    .rst_i     (rst_i),
    .sensores_i(sensores_i),
    .bomba_a_o (bomba_a_o),
    .bomba_b_o (bomba_b_o),
    .alarma_o  (alarma_o),
    .lider_o   (lider_o),
    .estado_o  (estado_o),
    .ciclos_o  (ciclos_o)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // Reference model: phase, edge count at phase entry, last invalid edge in fault
  int         m_ph;
  int         m_n;
  int         m_entry;
  int         m_bad;
  int         m_ldr;
  int         m_cyc;
  logic [2:0] m_hist[$];

  task automatic model_reset();
    m_ph = 0; m_n = 0; m_entry = 0; m_bad = 0; m_ldr = 0; m_cyc = 0;
    m_hist = {3'b000, 3'b000};
  endtask

  task automatic model_stop();
    m_ph = 3; m_entry = m_n; m_ldr = 1 - m_ldr;
    if (m_cyc < 255) m_cyc = m_cyc + 1;
  endtask

  // The FSM acts on the sensor value applied two edges earlier
  task automatic model_edge(input logic [2:0] x);
    logic [2:0] cur;
    bit         ok;
    cur = m_hist.pop_front();
    m_hist.push_back(x);
    m_n = m_n + 1;
    ok = (cur == 3'd0) || (cur == 3'd1) || (cur == 3'd3) || (cur == 3'd7);
    if (m_ph != 4 && !ok) begin
      m_ph = 4; m_entry = m_n; m_bad = m_n;
    end else begin
      case (m_ph)
        0: if (cur == 3'd0) begin m_ph = 1; m_entry = m_n; end
        1: begin
          if (cur == 3'd7 && (m_n - m_entry) >= MIN_ON) model_stop();
          else if (cur == 3'd0 && (m_n - m_entry) == ASSIST_CYC) begin m_ph = 2; m_entry = m_n; end
        end
        2: if (cur == 3'd7) model_stop();
        3: if ((m_n - m_entry) == MIN_OFF) begin m_ph = 0; m_entry = m_n; end
        default: begin
          if (!ok) m_bad = m_n;
          else if ((m_n - m_bad) >= MIN_OFF) begin m_ph = 3; m_entry = m_n; end
        end
      endcase
    end
  endtask

  function automatic logic [14:0] model_outs();
    logic a, b, al, l;
    logic [7:0] c;
    a  = (m_ph == 2) || (m_ph == 1 && m_ldr == 0);
    b  = (m_ph == 2) || (m_ph == 1 && m_ldr == 1);
    al = (m_ph == 4);
    l  = (m_ldr != 0);
    c  = CICLOS_EN ? 8'(m_cyc) : 8'd0;
    return {a, b, al, l, 3'(m_ph), c};
  endfunction

  function automatic logic [14:0] dut_outs();
    return {bomba_a_o, bomba_b_o, alarma_o, lider_o, estado_o, ciclos_o};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Apply one input for one edge, advance the model, compare all outputs
  task automatic step(input logic [2:0] v, input string nm);
    sensores_i = v;
    @(posedge ck);
    model_edge(v);
    #1;
    check(nm, 32'(dut_outs()), 32'(model_outs()));
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_a"}, 32'(bomba_a_o), 32'd0);
    check({nm, "_b"}, 32'(bomba_b_o), 32'd0);
    check({nm, "_alarm"}, 32'(alarma_o), 32'd0);
    check({nm, "_lider"}, 32'(lider_o), 32'd0);
    check({nm, "_estado"}, 32'(estado_o), 32'd0);
    check({nm, "_ciclos"}, 32'(ciclos_o), 32'd0);
  endtask

  // Assert reset between edges, check outputs clear at once, release after an edge
  task automatic do_reset(input string nm);
    #2;
    rst_i = 1'b1;
    #1;
    check_zero(nm);
    @(posedge ck);
    #1;
    rst_i = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [2:0] sens;
    int         n;
    logic [2:0] est;
    logic       a;
    logic       b;
    logic       al;
    logic       l;
  } vec_t;

  vec_t vt[16];

  initial begin
    tests = 0;
    fails = 0;
    rst_i = 1'b0;
    sensores_i = 3'b000;
    model_reset();

    // Directed sequence from reset (edge numbers counted after release)
    vt[0]  = '{3'b000,  3, 3'd1, 1, 0, 0, 0};  // sync flops reset to 000: run starts at edge 1
    vt[1]  = '{3'b011, 10, 3'd1, 1, 0, 0, 0};
    vt[2]  = '{3'b111,  3, 3'd1, 1, 0, 0, 0};  // full seen before min run: keep running
    vt[3]  = '{3'b111,  1, 3'd3, 0, 0, 0, 1};  // min run reached: rest, lead -> B
    vt[4]  = '{3'b000,  8, 3'd0, 0, 0, 0, 1};  // rest waited out despite demand
    vt[5]  = '{3'b000,  1, 3'd1, 0, 1, 0, 1};  // B leads, MIN_OFF+1 edges after rest entry
    vt[6]  = '{3'b000, 31, 3'd1, 0, 1, 0, 1};
    vt[7]  = '{3'b000,  1, 3'd2, 1, 1, 0, 1};  // assist 32 edges after run entry
    vt[8]  = '{3'b111,  3, 3'd3, 0, 0, 0, 0};  // both stop, lead toggles once
    vt[9]  = '{3'b101,  3, 3'd4, 0, 0, 1, 0};  // invalid code: fault, lead unchanged
    vt[10] = '{3'b011,  7, 3'd4, 0, 0, 1, 0};
    vt[11] = '{3'b110,  1, 3'd4, 0, 0, 1, 0};
    vt[12] = '{3'b011,  8, 3'd4, 0, 0, 1, 0};  // glitch restarted the valid count
    vt[13] = '{3'b011,  2, 3'd3, 0, 0, 0, 0};  // leaves fault into rest
    vt[14] = '{3'b001,  8, 3'd0, 0, 0, 0, 0};
    vt[15] = '{3'b001,  5, 3'd0, 0, 0, 0, 0};  // partial level does not start a run

    #2;
    rst_i = 1'b1;
    #1;
    check_zero("reset");
    @(posedge ck);
    @(posedge ck);
    #1;
    rst_i = 1'b0;
    model_reset();

    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < vt[i].n; k++) step(vt[i].sens, $sformatf("vec%0d_model", i));
      check($sformatf("vec%0d_estado", i), 32'(estado_o), 32'(vt[i].est));
      check($sformatf("vec%0d_a", i), 32'(bomba_a_o), 32'(vt[i].a));
      check($sformatf("vec%0d_b", i), 32'(bomba_b_o), 32'(vt[i].b));
      check($sformatf("vec%0d_alarm", i), 32'(alarma_o), 32'(vt[i].al));
      check($sformatf("vec%0d_lider", i), 32'(lider_o), 32'(vt[i].l));
    end

    // Async reset while pump A runs
    for (int k = 0; k < 3; k++) step(3'b000, "prerst_model");
    check("prerst_a", 32'(bomba_a_o), 32'd1);
    do_reset("async_rst");

    // Randomized segments against the model
    for (int seg = 0; seg < 160; seg++) begin
      logic [2:0] v;
      int r;
      int len;
      r = int'($urandom_range(0, 19));
      if (r < 7)       v = 3'b000;
      else if (r < 13) v = 3'b111;
      else if (r < 16) v = 3'b011;
      else if (r < 18) v = 3'b001;
      else             v = 3'($urandom_range(0, 7));
      len = int'($urandom_range(1, 24));
      for (int k = 0; k < len; k++) step(v, "rand_model");
    end

    // 300 short fill cycles for the completed-cycle counter
    do_reset("cyc_rst");
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < 4; k++) step(3'b000, "cyc_model");
      for (int k = 0; k < 24; k++) step(3'b111, "cyc_model");
    end
    check("ciclos_final", 32'(ciclos_o), CICLOS_EN ? 32'd255 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
